// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage driving a req/ack data memory port,
// with store lane steering, load extraction/extension and a stall request.
module mem_access_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic                  reg_wb_in,
    output logic                  reg_wb_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  stall_req,
    output logic                  misaligned_exc,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic                  killed_q, killed_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;

    logic                  live, memop, is_store, sz_byte, sz_half;
    logic                  misaligned, issue, drop;
    logic [3:0]            be_st;
    logic [DATA_WIDTH-1:0] wdata_st;
    logic [7:0]            ld_b;
    logic [15:0]           ld_h;
    logic [DATA_WIDTH-1:0] ld_val;

    // valid_in is masked during reset so every combinational output reads 0
    always_comb begin
        live           = valid_in & rst_n;
        memop          = live & (mem_read | mem_write);
        is_store       = mem_write & ~mem_read;
        sz_byte        = mem_size == 2'd0;
        sz_half        = mem_size == 2'd1;
        misaligned     = memop & (sz_half ? alu_result[0] : ~sz_byte & (alu_result[1:0] != 2'b00));
        issue          = (state_q == IDLE) & memop & ~misaligned & ~flush;
        drop           = killed_q | flush;
        misaligned_exc = (state_q == IDLE) & misaligned & ~flush;
        stall_req      = issue | (state_q == BUSY);
        reg_wb_out     = (state_q == IDLE) ? live & reg_wb_in & ~flush & ~memop
                                           : (state_q == DONE) & reg_wb_in & ~flush;
        data_out       = (state_q == IDLE) ? ((memop | ~rst_n) ? '0 : alu_result)
                                           : (state_q == DONE) ? result_q : '0;
        be_st          = sz_byte ? 4'b0001 << alu_result[1:0]
                                 : sz_half ? (alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_st       = sz_byte ? {4{store_data[7:0]}}
                                 : sz_half ? {2{store_data[15:0]}} : store_data;
        ld_b           = dmem_rdata[{off_q, 3'b000} +: 8];
        ld_h           = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_val         = (size_q == 2'd0) ? {{24{~uns_q & ld_b[7]}}, ld_b}
                       : (size_q == 2'd1) ? {{16{~uns_q & ld_h[15]}}, ld_h} : dmem_rdata;
    end

    always_comb begin
        state_d  = state_q;
        killed_d = killed_q;
        result_d = result_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        case (state_q)
            IDLE: if (issue) begin
                state_d = BUSY;
                req_d   = 1'b1;
                we_d    = is_store;
                addr_d  = {alu_result[ADDR_WIDTH-1:2], 2'b00};
                be_d    = is_store ? be_st : 4'b0000;
                wdata_d = wdata_st;
                off_d   = alu_result[1:0];
                size_d  = mem_size;
                uns_d   = mem_unsigned;
            end
            // a flushed request still has to see its ack before the bus is free
            BUSY: begin
                killed_d = drop;
                if (dmem_ack) begin
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    killed_d = 1'b0;
                    state_d  = drop ? IDLE : DONE;
                    result_d = drop ? result_q : we_q ? '0 : ld_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            killed_q <= 1'b0;
            result_q <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            off_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
            result_q <= result_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            off_q    <= off_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage. Sits between the EX/MEM register and the MEM/WB register, and feeds reg_wb/data into the MEM/WB register.
- Handles loads and stores to data memory through a req/ack handshake. Asserts stall_req while a transfer is outstanding.
- Generates byte enables and aligns load data with sign or zero extension.
- Non-memory instructions pass alu_result through with zero added latency.

Parameters:
- DATA_WIDTH, 32, datapath width. Only 32 is supported because byte-lane logic assumes 4 lanes.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill the instruction currently in MEM (hazard/exception unit)
- valid_in  in  1  EX/MEM holds a live instruction
- mem_read  in  1  load
- mem_write  in  1  store
- mem_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- mem_unsigned  in  1  zero-extend loads
- alu_result  in  DATA_WIDTH  effective address for mem ops, result for others
- store_data  in  DATA_WIDTH  rt value for stores
- reg_wb_in  in  1  instruction writes the register file
- reg_wb_out  out  1  to MEM/WB reg_wb_in
- data_out  out  DATA_WIDTH  to MEM/WB data_in
- stall_req  out  1  to hazard unit; freezes PC through EX/MEM
- misaligned_exc  out  1  address-error pulse to exception unit
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  write enable, registered
- dmem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}), registered
- dmem_be  out  4  byte enables, registered
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data, registered
- dmem_rdata  in  DATA_WIDTH  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset (async): state=IDLE, killed=0, result reg=0, all dmem_* outputs=0. Combinational outputs reg_wb_out, data_out, stall_req and misaligned_exc evaluate to 0 because valid_in is ignored in reset.
- memop = valid_in & (mem_read | mem_write). If mem_read and mem_write are both set, the access is a load.
- Misaligned when half with addr[0]=1, or word with addr[1:0]≠0.
  - Effect: misaligned_exc=1 combinationally; no request; stall_req=0; reg_wb_out=0; data_out=0.
- Non-memop while IDLE: reg_wb_out=reg_wb_in&valid_in&~flush; data_out=alu_result; stall_req=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on an aligned memop with flush=0. At that edge, register dmem_req=1, dmem_we=mem_write&~mem_read, dmem_addr, dmem_be, dmem_wdata, and latch addr[1:0], size and unsigned. stall_req=1 combinationally in this cycle.
  - BUSY: hold every dmem_* output stable, keep stall_req=1, and wait for dmem_ack.
    - On ack: dmem_req←0 and dmem_we←0. For a load, result←extracted rdata; for a store, result←0. Next state is DONE, or IDLE if killed.
  - DONE: lasts one cycle. stall_req=0; data_out=result; reg_wb_out=reg_wb_in&~flush. Next state is IDLE, when the upstream advances.
- Store lanes:
  - Byte: be=4'b0001<<addr[1:0]; wdata={4{sd[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata={2{sd[15:0]}}.
  - Word: be=1111; wdata=sd.
- Load extract:
  - Byte: rdata[8*addr[1:0]+:8].
  - Half: rdata[16*addr[1]+:16].
  - Extension is sign or zero according to mem_unsigned.
- Flush:
  - In IDLE or DONE: outputs gated (reg_wb_out=0); no request issued.
  - In BUSY: the request cannot be withdrawn. Set killed=1 and keep stall_req=1 until ack so the bus drains. On ack, discard the data and go to IDLE; killed←0.
- dmem_ack received while not in BUSY is ignored.
- Latency: a memory op occupies MEM for 1 + (cycles to ack) + 1 cycles. With an ack on the cycle after the request, the total is 3 cycles. A non-memop takes 0 extra cycles.
- Reset asserted in any state returns to IDLE immediately and drops dmem_req. Any outstanding memory response is dropped.

Test Plan:
- Non-memop pass-through: valid_in=1, reg_wb_in=1, alu_result=0x12345678 → same cycle reg_wb_out=1, data_out=0x12345678, stall_req=0, dmem_req stays 0.
- Signed byte load: addr=0x1003, size=0, unsigned=0, rdata=0x80FF0011, ack 2 cycles after req → dmem_addr=0x1000, be=0000, we=0; stall_req high through BUSY; in DONE data_out=0xFFFFFF80 and reg_wb_out=1.
- Half store: addr=0x2002, store_data=0xAABBCCDD → dmem_we=1, be=1100, wdata=0xCCDDCCDD; req held until ack, then DONE with reg_wb_out=reg_wb_in.
- Misaligned word load: addr=0x3001, size=2 → misaligned_exc=1 for one cycle, dmem_req stays 0, reg_wb_out=0, stall_req=0.
- Flush in BUSY: word load at 0x4000, flush pulsed 1 cycle after req, ack 3 cycles later with rdata=0xDEADBEEF → stall_req held until ack; state goes straight to IDLE; reg_wb_out never 1; data discarded.
- Async reset while BUSY: assert rst_n=0 mid-transfer → dmem_req=0 and stall_req=0 immediately; a later stray ack is ignored; the next load runs normally.
